// File: rtl/ss_stack_16b_pkg.sv
// Shared processor constants: stack operation encodings used by the stack
// control and the stack-pointer unit.
package ss_stack_16b_pkg;

   typedef enum logic [1:0] {
      OP_HOLD    = 2'd0,
      OP_PUSH    = 2'd1,
      OP_POP     = 2'd2,
      OP_REPLACE = 2'd3
   } op_e;

   // {pop, push} maps directly onto the pointer-unit select encoding.
   function automatic op_e decode_op(input logic push, input logic pop);
      return op_e'({pop, push});
   endfunction

endpackage

// File: rtl/ss_stack_ram.sv
// Stack storage: DEPTH x WIDTH, one synchronous write port, one asynchronous
// read port.
module ss_stack_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage has no reset; the stack pointer alone decides which entries
   // are meaningful, so clearing the array would only cost logic.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ss_stack_16b.sv
// Hardware LIFO stack: op decode, stack pointer, sticky error flags and the
// registered pop-data output around an ss_stack_ram.
module ss_stack_16b
   import ss_stack_16b_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                   CLK,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   input  logic                   clr_err,
   output logic [WIDTH-1:0]       dout,
   output logic                   dout_valid,
   output logic [WIDTH-1:0]       top,
   output logic [$clog2(DEPTH):0] sp,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = AW + 1;

   op_e            op;
   logic           push_ok;
   logic           pop_ok;
   logic           ovf_evt;
   logic           udf_evt;
   logic           we;
   logic [AW-1:0]  waddr;
   logic [SW-1:0]  sp_dec;
   logic [WIDTH-1:0] rdata;

   assign sp_dec = sp - SW'(1);
   assign full   = (sp == SW'(DEPTH));
   assign empty  = (sp == '0);
   assign top    = empty ? '0 : rdata;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      op      = decode_op(push, pop);
      push_ok = 1'b0;
      pop_ok  = 1'b0;
      ovf_evt = 1'b0;
      udf_evt = 1'b0;
      waddr   = sp[AW-1:0];
      unique case (op)
         OP_PUSH: begin
            push_ok = !full;
            ovf_evt = full;
         end
         OP_POP: begin
            pop_ok  = !empty;
            udf_evt = empty;
         end
         OP_REPLACE: begin
            // The write always fits: either the stack is empty or the pop frees the top slot.
            push_ok = 1'b1;
            pop_ok  = !empty;
            udf_evt = empty;
            if (!empty) waddr = sp_dec[AW-1:0];
         end
         default: ;
      endcase
      we = push_ok && !reset;
   end

   ss_stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk   (CLK),
      .we    (we),
      .waddr (waddr),
      .wdata (din),
      .raddr (sp_dec[AW-1:0]),
      .rdata (rdata)
   );

   // NOTE: all state updates use <= so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (reset) begin
         sp         <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (push_ok && !pop_ok)      sp <= sp + SW'(1);
         else if (pop_ok && !push_ok) sp <= sp_dec;
         if (pop_ok) dout <= rdata;
         dout_valid <= pop_ok;
         // A new error event wins over a coincident clear.
         overflow   <= ovf_evt | (overflow & ~clr_err);
         underflow  <= udf_evt | (underflow & ~clr_err);
      end
   end

endmodule

// File: tb/tb_ss_stack_16b.sv
// Self-checking bench for ss_stack_16b: directed scenarios plus randomized
// traffic compared against a queue-based LIFO model.
module tb_ss_stack_16b;

   localparam int DEPTH = 16;

   logic        CLK = 1'b0;
   logic        reset, push, pop, clr_err;
   logic [15:0] din;
   logic [15:0] dout, top;
   logic        dout_valid, full, empty, overflow, underflow;
   logic [4:0]  sp;

   int checks = 0;
   int errors = 0;

   // Behavioural model
   logic [15:0] mq[$];
   logic [15:0] m_dout;
   logic        m_dv, m_ovf, m_udf;

   ss_stack_16b #(.WIDTH(16), .DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .din        (din),
      .clr_err    (clr_err),
      .dout       (dout),
      .dout_valid (dout_valid),
      .top        (top),
      .sp         (sp),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 CLK = ~CLK;

   // Apply one cycle of stimulus, advance the model, leave outputs sampled #1 after the edge.
   task automatic cyc(input logic p, input logic po, input logic [15:0] d,
                      input logic c, input logic r);
      bit so, su;
      push = p; pop = po; din = d; clr_err = c; reset = r;
      @(posedge CLK);
      #1;
      so = 0; su = 0;
      if (r) begin
         mq.delete();
         m_dout = '0; m_dv = 0; m_ovf = 0; m_udf = 0;
      end else begin
         m_dv = 0;
         if (p && po) begin
            if (mq.size() == 0) begin
               mq.push_back(d);
               su = 1;
            end else begin
               m_dout = mq[$];
               mq[$]  = d;
               m_dv   = 1;
            end
         end else if (p) begin
            if (mq.size() == DEPTH) so = 1;
            else mq.push_back(d);
         end else if (po) begin
            if (mq.size() == 0) su = 1;
            else begin
               m_dout = mq.pop_back();
               m_dv   = 1;
            end
         end
         m_ovf = so | (m_ovf & !c);
         m_udf = su | (m_udf & !c);
      end
      push = 0; pop = 0; din = '0; clr_err = 0; reset = 0;
   endtask

   task automatic test_reset();
      cyc(1, 1, 16'h7777, 0, 1);
      cyc(0, 0, 16'h0000, 0, 1);
      checks++; if (sp !== 5'd0)        begin errors++; $display("FAIL reset_sp: got %0d want 0", sp); end
      checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
      checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      checks++; if (dout !== 16'h0)     begin errors++; $display("FAIL reset_dout: got %h want 0000", dout); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", dout_valid); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); end
      checks++; if (top !== 16'h0)      begin errors++; $display("FAIL reset_top: got %h want 0000", top); end
   endtask

   task automatic test_push_pop();
      logic [15:0] exp_d;
      for (int i = 1; i <= 3; i++) cyc(1, 0, 16'(i), 0, 0);
      checks++; if (sp !== 5'd3)        begin errors++; $display("FAIL push3_sp: got %0d want 3", sp); end
      checks++; if (top !== 16'h0003)   begin errors++; $display("FAIL push3_top: got %h want 0003", top); end
      checks++; if (empty !== 1'b0)     begin errors++; $display("FAIL push3_empty: got %b want 0", empty); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL push3_flags: got %b want 00", {overflow, underflow}); end
      for (int i = 3; i >= 1; i--) begin
         exp_d = 16'(i);
         cyc(0, 1, 16'h0, 0, 0);
         checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL pop%0d_dv: got %b want 1", i, dout_valid); end
         checks++; if (dout !== exp_d)      begin errors++; $display("FAIL pop%0d_dout: got %h want %h", i, dout, exp_d); end
         cyc(0, 0, 16'h0, 0, 0);
         checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL pop%0d_dv_pulse: got %b want 0", i, dout_valid); end
         checks++; if (dout !== exp_d)      begin errors++; $display("FAIL pop%0d_dout_hold: got %h want %h", i, dout, exp_d); end
      end
      checks++; if (sp !== 5'd0)    begin errors++; $display("FAIL drain_sp: got %0d want 0", sp); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
   endtask

   task automatic test_underflow();
      cyc(0, 1, 16'h0, 0, 0);
      checks++; if (underflow !== 1'b1)  begin errors++; $display("FAIL udf_set: got %b want 1", underflow); end
      checks++; if (dout !== 16'h0001)   begin errors++; $display("FAIL udf_dout: got %h want 0001", dout); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL udf_dv: got %b want 0", dout_valid); end
      checks++; if (sp !== 5'd0)         begin errors++; $display("FAIL udf_sp: got %0d want 0", sp); end
      cyc(0, 1, 16'h0, 1, 0);
      checks++; if (underflow !== 1'b1)  begin errors++; $display("FAIL udf_clr_race: got %b want 1", underflow); end
      cyc(0, 0, 16'h0, 1, 0);
      checks++; if (underflow !== 1'b0)  begin errors++; $display("FAIL udf_clr: got %b want 0", underflow); end
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 16'h0010 + 16'(i), 0, 0);
      checks++; if (full !== 1'b1)     begin errors++; $display("FAIL full_set: got %b want 1", full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
      cyc(1, 0, 16'hFFFF, 0, 0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      checks++; if (top !== 16'h001F)  begin errors++; $display("FAIL ovf_top: got %h want 001F", top); end
      checks++; if (sp !== 5'd16)      begin errors++; $display("FAIL ovf_sp: got %0d want 16", sp); end
      cyc(1, 1, 16'hAAAA, 1, 0);
      checks++; if (dout !== 16'h001F)   begin errors++; $display("FAIL repl_full_dout: got %h want 001F", dout); end
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL repl_full_dv: got %b want 1", dout_valid); end
      checks++; if (top !== 16'hAAAA)    begin errors++; $display("FAIL repl_full_top: got %h want AAAA", top); end
      checks++; if (sp !== 5'd16)        begin errors++; $display("FAIL repl_full_sp: got %0d want 16", sp); end
      checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL repl_full_no_ovf: got %b want 0", overflow); end
   endtask

   task automatic test_replace_empty();
      cyc(0, 0, 16'h0, 0, 1);
      cyc(1, 1, 16'h1234, 0, 0);
      checks++; if (sp !== 5'd1)         begin errors++; $display("FAIL repl_empty_sp: got %0d want 1", sp); end
      checks++; if (top !== 16'h1234)    begin errors++; $display("FAIL repl_empty_top: got %h want 1234", top); end
      checks++; if (underflow !== 1'b1)  begin errors++; $display("FAIL repl_empty_udf: got %b want 1", underflow); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL repl_empty_dv: got %b want 0", dout_valid); end
   endtask

   task automatic test_reset_mid();
      cyc(1, 0, 16'h5555, 0, 1);
      checks++; if (sp !== 5'd0)        begin errors++; $display("FAIL rst_push_sp: got %0d want 0", sp); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_push_udf: got %b want 0", underflow); end
      cyc(1, 0, 16'h0777, 0, 0);
      checks++; if (sp !== 5'd1)        begin errors++; $display("FAIL rst_pre_sp: got %0d want 1", sp); end
      cyc(0, 1, 16'h0, 0, 1);
      checks++; if (sp !== 5'd0)         begin errors++; $display("FAIL rst_pop_sp: got %0d want 0", sp); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_pop_dv: got %b want 0", dout_valid); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL rst_pop_flags: got %b want 00", {overflow, underflow}); end
      checks++; if (dout !== 16'h0)      begin errors++; $display("FAIL rst_pop_dout: got %h want 0000", dout); end
   endtask

   task automatic test_random();
      logic        p, po, c, r;
      int          bias;
      logic [15:0] exp_top;
      for (int i = 0; i < 2000; i++) begin
         bias = ((i / 100) % 2) ? 70 : 30;
         p  = ($urandom_range(0, 99) < bias);
         po = ($urandom_range(0, 99) < (100 - bias));
         c  = ($urandom_range(0, 15) == 0);
         r  = ($urandom_range(0, 199) == 0);
         cyc(p, po, 16'($urandom), c, r);
         exp_top = (mq.size() != 0) ? mq[$] : 16'h0;
         checks++; if (sp !== 5'(mq.size()))  begin errors++; $display("FAIL rnd%0d_sp: got %0d want %0d", i, sp, mq.size()); end
         checks++; if (top !== exp_top)       begin errors++; $display("FAIL rnd%0d_top: got %h want %h", i, top, exp_top); end
         checks++; if (full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd%0d_full: got %b want %b", i, full, mq.size() == DEPTH); end
         checks++; if (empty !== (mq.size() == 0))    begin errors++; $display("FAIL rnd%0d_empty: got %b want %b", i, empty, mq.size() == 0); end
         checks++; if (dout !== m_dout)       begin errors++; $display("FAIL rnd%0d_dout: got %h want %h", i, dout, m_dout); end
         checks++; if (dout_valid !== m_dv)   begin errors++; $display("FAIL rnd%0d_dv: got %b want %b", i, dout_valid, m_dv); end
         checks++; if (overflow !== m_ovf)    begin errors++; $display("FAIL rnd%0d_ovf: got %b want %b", i, overflow, m_ovf); end
         checks++; if (underflow !== m_udf)   begin errors++; $display("FAIL rnd%0d_udf: got %b want %b", i, underflow, m_udf); end
      end
   endtask

   initial begin
      reset = 1; push = 0; pop = 0; din = '0; clr_err = 0;
      m_dout = '0; m_dv = 0; m_ovf = 0; m_udf = 0;
      test_reset();
      test_push_pop();
      test_underflow();
      test_full();
      test_replace_empty();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
